vme_lbus_ctrl: RTL
==================

# vme_lbus_ctrl

Local-bus master controller between the VME slave decode logic and the local (PLX-style) bus. Arbitrates two requesters, the VME slave path and the internal interrupt/config path, for one shared local-bus master port. For each granted request it runs a single LHOLD/LHOLDA acquisition followed by one ADSn/READYn data cycle. It returns read data with ACK, or signals ERR on timeout or loss of hold.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum cycles spent in HOLD+DATA before ERR; range 1..1023
- CLOCK  in  1  system clock, rising edge
- RESETn  in  1  asynchronous, active-low reset
- VME_REQ  in  1  VME requester request; level, held until VME_ACK or VME_ERR
- VME_WR  in  1  1 = write, 0 = read
- VME_ADDR  in  AW  address
- VME_WDATA  in  DW  write data
- VME_ACK  out  1  one-cycle completion pulse
- VME_ERR  out  1  one-cycle error pulse
- VME_RDATA  out  DW  read data; valid with VME_ACK, held until next read completion
- INT_REQ / INT_WR / INT_ADDR / INT_WDATA / INT_ACK / INT_ERR / INT_RDATA  same as VME_*, internal requester
- LHOLD  out  1  local bus hold request, active high
- LHOLDA  in  1  hold acknowledge, active high
- ADSn  out  1  address strobe, active low
- LW_Rn  out  1  1 = write, 0 = read
- LAD_OUT  out  DW  address/data driven onto LAD_BUS
- LAD_OE  out  1  LAD_BUS output enable (tristate at top level)
- LAD_IN  in  DW  LAD_BUS sampled value
- READYn  in  1  target ready, active low
- BUSY  out  1  high in every state except IDLE

## Operation
- All outputs are registered. Reset values: LHOLD=0, ADSn=1, LW_Rn=0, LAD_OE=0, LAD_OUT=0, all ACK/ERR=0, all RDATA=0, BUSY=0.
- States: IDLE, HOLD, ADDR, DATA, DONE.
- IDLE: on any REQ, grant one requester. If only one requests, grant it. If both request, round-robin: grant the requester not granted last. The last-granted flag resets to INT, so VME wins the first tie. Latch WR/ADDR/WDATA of the grantee. Go to HOLD.
- HOLD: LHOLD=1. On LHOLDA=1, go to ADDR.
- ADDR, exactly one cycle: ADSn=0, LAD_OE=1, LAD_OUT=address, LW_Rn=latched WR.
- DATA: ADSn=1. Write: LAD_OE=1, LAD_OUT=wdata. Read: LAD_OE=0. On READYn=0, capture LAD_IN into the grantee's RDATA (read only) and go to DONE with success.
- DONE, one cycle: grantee ACK=1, or ERR=1 on failure. LHOLD=0, LAD_OE=0, LW_Rn=0. Go to IDLE.
- Timeout: a 10-bit counter clears on IDLE→HOLD and increments each cycle in HOLD and DATA. If it reaches TIMEOUT before the exit condition, go to DONE with ERR. RDATA is unchanged on ERR.
- LHOLDA=0 sampled in ADDR or DATA: abort, go to DONE with ERR. READYn is ignored in that cycle.
- READYn=0 and timeout in the same cycle: READYn wins, so the result is ACK.
- Non-granted REQ stays pending and is not acknowledged. The grantee must deassert REQ at the edge where it samples ACK/ERR=1. IDLE re-samples on the following edge.
- ACK and ERR are never both high. Only the grantee's pair pulses.
- RESETn low at any time, including mid-cycle: all outputs return to reset values immediately and the state goes to IDLE. The transaction is lost with no ACK/ERR.

## Timing
- Request sampled in IDLE at edge 0: HOLD in cycle 1, ADDR in cycle 2 (if LHOLDA=1 at edge 1→2), DATA in cycle 3, DONE in cycle 4 (if READYn=0 at edge 3→4).
- Minimum request-to-ACK: 4 cycles. Each extra LHOLDA or READYn wait cycle adds 1 cycle.
- Back-to-back: the next grant is sampled 1 cycle after DONE. LHOLD is low for at least 1 cycle between transactions.
- ADSn is low for exactly 1 cycle per transaction and never in HOLD, DATA or DONE.

## Test plan
- VME read, 0x0018_0050; LHOLDA=1, READYn=0, LAD_IN=0x1234_5678 → ADSn low in cycle 2, VME_ACK in cycle 4, VME_RDATA=0x1234_5678, LHOLD low in cycle 4.
- INT write, 0x5500_0004 / 0x0000_0055; READYn held high 3 extra cycles → LAD_OUT=0x5500_0004 with ADSn, then 0x0000_0055 with LAD_OE=1, LW_Rn=1; INT_ACK in cycle 7.
- VME_REQ and INT_REQ rise together, both held → VME served first, then INT. A second simultaneous pair is served VME then INT again (alternation). No overlapping LHOLD.
- TIMEOUT=8, READYn stuck high → VME_ERR exactly when the counter hits 8, RDATA unchanged, LHOLD released. LHOLDA never asserted → INT_ERR after 8 HOLD cycles.
- LHOLDA dropped in DATA → ERR in the next cycle, no ACK. RESETn pulsed low mid-DATA → LHOLD=0, ADSn=1, LAD_OE=0 immediately, BUSY=0, no ACK/ERR, next request served normally.

Source files
------------

// File: rtl/vme_lbus_ctrl.sv
// Local-bus master shared by the VME slave path and the internal interrupt/config path.
// Each grant runs one LHOLD/LHOLDA acquisition and one ADSn/READYn data cycle, ending in ACK or ERR.
module vme_lbus_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          CLOCK,
  input  logic          RESETn,

  input  logic          VME_REQ,
  input  logic          VME_WR,
  input  logic [AW-1:0] VME_ADDR,
  input  logic [DW-1:0] VME_WDATA,
  output logic          VME_ACK,
  output logic          VME_ERR,
  output logic [DW-1:0] VME_RDATA,

  input  logic          INT_REQ,
  input  logic          INT_WR,
  input  logic [AW-1:0] INT_ADDR,
  input  logic [DW-1:0] INT_WDATA,
  output logic          INT_ACK,
  output logic          INT_ERR,
  output logic [DW-1:0] INT_RDATA,

  output logic          LHOLD,
  input  logic          LHOLDA,
  output logic          ADSn,
  output logic          LW_Rn,
  output logic [DW-1:0] LAD_OUT,
  output logic          LAD_OE,
  input  logic [DW-1:0] LAD_IN,
  input  logic          READYn,
  output logic          BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic        GNT_VME   = 1'b0;
  localparam logic        GNT_INT   = 1'b1;
  localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT);

  state_t        state_q, state_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [10:0]   cnt_inc;
  logic          timed_out;
  logic          done_ok;

  // grant_q doubles as the last-granted flag for round-robin tie breaks
  logic          grant_q, grant_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          lhold_q, lhold_d;
  logic          ads_n_q, ads_n_d;
  logic          lw_rn_q, lw_rn_d;
  logic          lad_oe_q, lad_oe_d;
  logic [DW-1:0] lad_out_q, lad_out_d;
  logic          busy_q, busy_d;
  logic          vme_ack_q, vme_ack_d;
  logic          vme_err_q, vme_err_d;
  logic          int_ack_q, int_ack_d;
  logic          int_err_q, int_err_d;
  logic [DW-1:0] vme_rdata_q, vme_rdata_d;
  logic [DW-1:0] int_rdata_q, int_rdata_d;

  assign cnt_inc   = {1'b0, cnt_q} + 11'd1;
  assign timed_out = (cnt_inc >= TIMEOUT_C);

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (VME_REQ || INT_REQ) begin
          if (VME_REQ && INT_REQ) grant_d = ~grant_q;
          else                    grant_d = INT_REQ ? GNT_INT : GNT_VME;
          wr_d    = (grant_d == GNT_INT) ? INT_WR    : VME_WR;
          addr_d  = (grant_d == GNT_INT) ? INT_ADDR  : VME_ADDR;
          wdata_d = (grant_d == GNT_INT) ? INT_WDATA : VME_WDATA;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_inc[9:0];
        if (LHOLDA)         state_d = S_ADDR;
        else if (timed_out) state_d = S_DONE;
      end
      S_ADDR: begin
        state_d = LHOLDA ? S_DATA : S_DONE;
      end
      S_DATA: begin
        // Lost hold beats READYn; READYn beats the timeout
        cnt_d = cnt_inc[9:0];
        if (!LHOLDA) begin
          state_d = S_DONE;
        end else if (!READYn) begin
          state_d = S_DONE;
          done_ok = 1'b1;
        end else if (timed_out) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lhold_d     = state_d inside {S_HOLD, S_ADDR, S_DATA};
    ads_n_d     = (state_d != S_ADDR);
    lw_rn_d     = (state_d inside {S_ADDR, S_DATA}) && wr_q;
    lad_oe_d    = (state_d == S_ADDR) || ((state_d == S_DATA) && wr_q);
    busy_d      = (state_d != S_IDLE);
    lad_out_d   = lad_out_q;
    if (state_d == S_ADDR)              lad_out_d = DW'(addr_q);
    else if (state_d == S_DATA && wr_q) lad_out_d = wdata_q;
    vme_ack_d   = (state_d == S_DONE) &&  done_ok && (grant_q == GNT_VME);
    vme_err_d   = (state_d == S_DONE) && !done_ok && (grant_q == GNT_VME);
    int_ack_d   = (state_d == S_DONE) &&  done_ok && (grant_q == GNT_INT);
    int_err_d   = (state_d == S_DONE) && !done_ok && (grant_q == GNT_INT);
    vme_rdata_d = vme_rdata_q;
    int_rdata_d = int_rdata_q;
    if (done_ok && !wr_q) begin
      if (grant_q == GNT_VME) vme_rdata_d = LAD_IN;
      else                    int_rdata_d = LAD_IN;
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      grant_q     <= GNT_INT;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lhold_q     <= 1'b0;
      ads_n_q     <= 1'b1;
      lw_rn_q     <= 1'b0;
      lad_oe_q    <= 1'b0;
      lad_out_q   <= '0;
      busy_q      <= 1'b0;
      vme_ack_q   <= 1'b0;
      vme_err_q   <= 1'b0;
      int_ack_q   <= 1'b0;
      int_err_q   <= 1'b0;
      vme_rdata_q <= '0;
      int_rdata_q <= '0;
    end else begin
      grant_q     <= grant_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lhold_q     <= lhold_d;
      ads_n_q     <= ads_n_d;
      lw_rn_q     <= lw_rn_d;
      lad_oe_q    <= lad_oe_d;
      lad_out_q   <= lad_out_d;
      busy_q      <= busy_d;
      vme_ack_q   <= vme_ack_d;
      vme_err_q   <= vme_err_d;
      int_ack_q   <= int_ack_d;
      int_err_q   <= int_err_d;
      vme_rdata_q <= vme_rdata_d;
      int_rdata_q <= int_rdata_d;
    end
  end

  assign LHOLD     = lhold_q;
  assign ADSn      = ads_n_q;
  assign LW_Rn     = lw_rn_q;
  assign LAD_OE    = lad_oe_q;
  assign LAD_OUT   = lad_out_q;
  assign BUSY      = busy_q;
  assign VME_ACK   = vme_ack_q;
  assign VME_ERR   = vme_err_q;
  assign INT_ACK   = int_ack_q;
  assign INT_ERR   = int_err_q;
  assign VME_RDATA = vme_rdata_q;
  assign INT_RDATA = int_rdata_q;

endmodule
